// File: rtl/dct_transpose_buffer.sv
// Transpose buffer between the row-pass and column-pass 1-D DCT stages: rows in, columns out.
// Define DCT_TRANSPOSE_PINGPONG_EN for two banks so block n+1 is written while block n is read.
module dct_transpose_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0] out_data,
  output logic [$clog2(DATA_DEPTH)-1:0]    out_col_idx,
  output logic                             out_last
);

  // state | meaning
  // EMPTY | bank may be written row by row, never read
  // FULL  | bank holds a complete block, read column by column, never written
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

`ifdef DCT_TRANSPOSE_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int            AW   = $clog2(DATA_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DATA_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [NBANK][DATA_DEPTH][DATA_DEPTH];

  bank_state_t   state_q [NBANK];
  bank_state_t   state_d [NBANK];
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [AW-1:0] wr_row_q, wr_row_d;
  logic [AW-1:0] rd_col_q, rd_col_d;
  logic          wr_fire, rd_fire;

  // Both flags come from registered bank state only, so no input-to-output combinational path.
  assign in_ready    = (state_q[wr_sel_q] == EMPTY);
  assign out_valid   = (state_q[rd_sel_q] == FULL);
  assign wr_fire     = in_valid && in_ready;
  assign rd_fire     = out_valid && out_ready;
  assign out_col_idx = rd_col_q;
  assign out_last    = out_valid && (rd_col_q == LAST);

  always_comb begin
    state_d  = state_q;
    wr_sel_d = wr_sel_q;
    wr_row_d = wr_row_q;
    rd_sel_d = rd_sel_q;
    rd_col_d = rd_col_q;
    if (wr_fire) begin
      wr_row_d = wr_row_q + AW'(1);
      if (wr_row_q == LAST) begin
        wr_row_d          = '0;
        state_d[wr_sel_q] = FULL;
`ifdef DCT_TRANSPOSE_PINGPONG_EN
        wr_sel_d          = ~wr_sel_q;
`endif
      end
    end
    if (rd_fire) begin
      rd_col_d = rd_col_q + AW'(1);
      if (rd_col_q == LAST) begin
        rd_col_d          = '0;
        state_d[rd_sel_q] = EMPTY;
`ifdef DCT_TRANSPOSE_PINGPONG_EN
        rd_sel_d          = ~rd_sel_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NBANK; b++) state_q[b] <= EMPTY;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_row_q <= '0;
      rd_col_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_row_q <= wr_row_d;
      rd_col_q <= rd_col_d;
    end
  end

  // Storage is not reset; a bank is only readable after a full block has been written into it.
  always_ff @(posedge clk) begin
    if (wr_fire && !reset) begin
      for (int j = 0; j < DATA_DEPTH; j++)
        mem[wr_sel_q][wr_row_q][j] <= in_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int r = 0; r < DATA_DEPTH; r++)
        out_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[rd_sel_q][r][rd_col_q];
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Scoreboard bench for dct_transpose_buffer: accepted rows feed a transpose model, a monitor checks columns.
// Timing expectations follow DCT_TRANSPOSE_PINGPONG_EN when it is defined for the build.
module tb_dct_transpose_buffer;
  localparam int DW = 32;
  localparam int DD = 8;
  localparam int W  = DW * DD;
`ifdef DCT_TRANSPOSE_PINGPONG_EN
  localparam int EXP_STALL = 0;
  localparam int EXP_LAST  = 31;
`else
  localparam int EXP_STALL = 16;
  localparam int EXP_LAST  = 47;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_col_idx;
  logic         out_last;

  dct_transpose_buffer #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col_idx(out_col_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
  } exp_t;

  exp_t         exp_q [$];
  logic [W-1:0] rows_q [$];
  exp_t         e_tmp;
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           rdy_mode = 0;
  int           stall_cnt = 0;
  int           first_in_cyc = -1;
  int           first_out_cyc = -1;
  int           last_out_cyc = -1;
  bit           have_prev = 0;
  logic [W-1:0] prev_data;
  logic [2:0]   prev_idx;
  logic         prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor and transpose model, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      rows_q.delete();
      have_prev = 0;
    end else begin
      if (have_prev) begin
        check("stall_valid", W'(out_valid), W'(1));
        check("stall_data", out_data, prev_data);
        check("stall_idx", W'(out_col_idx), W'(prev_idx));
        check("stall_last", W'(out_last), W'(prev_last));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_column: got idx %0d data %h expected no output", out_col_idx, out_data);
        end else begin
          check("col_data", out_data, exp_q[0].data);
          check("col_idx", W'(out_col_idx), W'(exp_q[0].idx));
          check("col_last", W'(out_last), W'(exp_q[0].last));
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
          end
        end
        have_prev = !out_ready;
        prev_data = out_data;
        prev_idx  = out_col_idx;
        prev_last = out_last;
      end else begin
        check("idle_data_zero", out_data, '0);
        check("idle_last_low", W'(out_last), '0);
        have_prev = 0;
      end
      if (in_valid && in_ready) begin
        rows_q.push_back(in_data);
        if (rows_q.size() == DD) begin
          for (int c = 0; c < DD; c++) begin
            e_tmp.data = '0;
            for (int r = 0; r < DD; r++) e_tmp.data[r*DW +: DW] = rows_q[r][c*DW +: DW];
            e_tmp.idx  = c;
            e_tmp.last = (c == DD - 1);
            exp_q.push_back(e_tmp);
          end
          rows_q.delete();
        end
      end
    end
  end

  // out_ready driver: 0 = always high, 1 = fixed stall pattern, 2 = random.
  initial begin
    bit pat [6];
    int pidx;
    pat = '{1, 0, 0, 1, 0, 1};
    pidx = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin out_ready = pat[pidx % 6]; pidx++; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Entered and left at posedge+1. gaps: 0 none, 1 alternate cycles, 2 random.
  task automatic send_rows(input int n, input int gaps, input bit pattern, input int budget);
    int sent = 0;
    int t = 0;
    while (sent < n && t < budget) begin
      case (gaps)
        1: in_valid = (t % 2 == 0);
        2: in_valid = 1'($urandom_range(0, 1));
        default: in_valid = 1'b1;
      endcase
      for (int j = 0; j < DD; j++)
        in_data[j*DW +: DW] = pattern ? DW'((sent % DD) * DD + j) : DW'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (first_in_cyc < 0) first_in_cyc = cyc;
        sent++;
      end else if (in_valid) begin
        stall_cnt++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (sent < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got %0d rows accepted expected %0d", sent, n);
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    check("drain_all_columns_out", W'(exp_q.size()), '0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = {8{$urandom}};
    @(posedge clk);
    #1;
    in_data = {8{$urandom}};
    @(negedge clk);
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), '0);
    check("reset_out_data", out_data, '0);
    check("reset_col_idx", W'(out_col_idx), '0);
    check("reset_out_last", W'(out_last), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;

    // single block, pattern rows, then latency of out_valid
    rdy_mode = 0;
    send_rows(DD, 0, 1'b1, 50);
    @(negedge clk);
    check("latency_out_valid", W'(out_valid), W'(1));
    check("latency_col_idx", W'(out_col_idx), '0);
    drain(100);

    // output backpressure with fixed pattern
    rdy_mode = 1;
    send_rows(DD, 0, 1'b0, 50);
    drain(200);

    // input gaps on alternate cycles
    rdy_mode = 0;
    send_rows(DD, 1, 1'b1, 50);
    drain(100);

    // streaming three blocks
    stall_cnt = 0;
    first_in_cyc = -1;
    first_out_cyc = -1;
    send_rows(3 * DD, 0, 1'b0, 200);
    drain(200);
    check("stream_in_stalls", W'(stall_cnt), W'(EXP_STALL));
    check("stream_first_col_cycle", W'(first_out_cyc - first_in_cyc), W'(8));
    check("stream_last_col_cycle", W'(last_out_cyc - first_in_cyc), W'(EXP_LAST));

    // reset mid-block
    send_rows(5, 0, 1'b0, 50);
    reset = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", W'(out_valid), '0);
    check("midreset_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    send_rows(DD, 0, 1'b0, 50);
    drain(100);

    // random gaps, random backpressure, random data
    rdy_mode = 2;
    send_rows(4 * DD, 2, 1'b0, 1000);
    drain(500);
    rdy_mode = 0;

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "timeout");
  end
endmodule
